// File: rtl/sgemm_pkg.sv
// rtl/sgemm_pkg.sv - shared widths, lane/line types and drain FSM states
// Contents:
//   LANE_W        width of one per-column result lane
//   LINE_W        width of one drained output line (two lanes)
//   lane_t/line_t packed vector types for lanes and lines
//   drain_state_t read FSM states of the C drain
//   clog2_min1    $clog2 clamped to at least 1 bit for index widths
package sgemm_pkg;

  localparam int LANE_W = 256;
  localparam int LINE_W = 512;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_LO,
    RD_HI
  } drain_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drain_line_fifo.sv
// rtl/drain_line_fifo.sv - synchronous 512-bit line FIFO with occupancy count
// Ports:
//   clk        clock
//   reset      synchronous, active-high; empties the FIFO
//   push       write push_data (ignored when full)
//   push_data  line to enqueue
//   pop        remove head (ignored when empty)
//   head_data  current head line, zero when empty
//   head_valid FIFO not empty
//   count      number of stored lines, 0..DEPTH
module drain_line_fifo
  import sgemm_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  line_t         push_data,
  input  logic          pop,
  output line_t         head_data,
  output logic          head_valid,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  line_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign head_valid = (count != '0);
  assign push_ok    = push && (count != CW'(DEPTH));
  assign pop_ok     = pop && head_valid;

  // Gate the head so the output reads zero whenever nothing is queued.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/drain_ram_256.sv
// rtl/drain_ram_256.sv - simple dual-port 256-bit RAM with registered read
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write lane
//   raddr  read address, sampled every cycle
//   rdata  read lane, valid one cycle after raddr
module drain_ram_256
  import sgemm_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  lane_t         wdata,
  input  logic [AW-1:0] raddr,
  output lane_t         rdata
);

  lane_t mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/drain_c.sv
// rtl/drain_c.sv - double-buffered C result drain, 256-bit lanes in, 512-bit lines out
// Ports:
//   clk            clock
//   reset          synchronous, active-high
//   res_valid      result beat valid, every column lane carries data
//   res_data       NUM_COL lanes, lane c at [(c+1)*256-1 : c*256]
//   res_ready      a beat can be accepted (fewer than two full banks)
//   out_valid      out_data holds a line
//   out_data       line: [255:0] even row, [511:256] odd row
//   out_ready      downstream accepts the line
//   block_done     one-cycle pulse after the last line of a block is taken
//   overflow_err   sticky: a beat arrived while res_ready was low
//   blocks_drained completed block count, wraps at 2^16
module drain_c
  import sgemm_pkg::*;
#(
  parameter int NUM_COL        = 2,
  parameter int ROWS_PER_BLOCK = 256,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      res_valid,
  input  logic [NUM_COL*LANE_W-1:0] res_data,
  output logic                      res_ready,
  output logic                      out_valid,
  output logic [LINE_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic                      block_done,
  output logic                      overflow_err,
  output logic [15:0]               blocks_drained
);

  localparam int ROW_AW          = clog2_min1(ROWS_PER_BLOCK);
  localparam int ADDR_W          = ROW_AW + 1;
  localparam int COL_W           = clog2_min1(NUM_COL);
  localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W           = CNT_W + 1;
  localparam int LINES_PER_BLOCK = NUM_COL * ROWS_PER_BLOCK / 2;
  localparam int OUT_W           = clog2_min1(LINES_PER_BLOCK);

  // ---------------- write side ----------------
  logic [ROW_AW-1:0] wr_row;
  logic              wr_shadow;
  logic [1:0]        bank_count;
  logic              wr_en;
  logic              wr_done;
  logic [ADDR_W-1:0] wr_addr;

  assign res_ready = (bank_count < 2'd2);
  assign wr_en     = res_valid && res_ready;
  assign wr_done   = wr_en && (wr_row == ROW_AW'(ROWS_PER_BLOCK - 1));
  assign wr_addr   = {wr_shadow, wr_row};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_row       <= '0;
      wr_shadow    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_done) begin
          wr_row    <= '0;
          wr_shadow <= ~wr_shadow;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (res_valid && !res_ready) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // ---------------- read side ----------------
  drain_state_t      state;
  logic [ROW_AW-1:0] rd_line;
  logic [COL_W-1:0]  rd_col;
  logic              rd_shadow;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              last_line;
  logic              last_col;
  logic              block_end;
  logic              release_bank;
  logic              bank_avail;
  logic              room;
  logic              can_issue;
  logic [ROW_AW-1:0] rd_row;
  logic [ADDR_W-1:0] rd_addr;

  assign last_line    = (rd_line == ROW_AW'(ROWS_PER_BLOCK / 2 - 1));
  assign last_col     = (rd_col == COL_W'(NUM_COL - 1));
  assign block_end    = last_line && last_col;
  assign release_bank = (state == RD_HI) && block_end;

  // A bank completing this very cycle already counts as readable; its rows
  // are all in the RAM by the time the first read lands next cycle.
  assign bank_avail   = (bank_count != 2'd0) || wr_done;

  // Lines already issued but not yet pushed reserve their FIFO slot.
  assign room      = ({1'b0, fifo_count} + {1'b0, inflight}) <= SUM_W'(FIFO_DEPTH - 1);
  assign can_issue = bank_avail && room;

  assign rd_row  = ROW_AW'({rd_line, (state == RD_HI)});
  assign rd_addr = {rd_shadow, rd_row};

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_count <= 2'd0;
    end else begin
      case ({wr_done, release_bank})
        2'b10:   bank_count <= bank_count + 2'd1;
        2'b01:   bank_count <= bank_count - 2'd1;
        default: bank_count <= bank_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_line   <= '0;
      rd_col    <= '0;
      rd_shadow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (can_issue) begin
            state <= RD_LO;
          end
        end
        RD_LO: begin
          state <= RD_HI;
        end
        RD_HI: begin
          if (last_line) begin
            rd_line <= '0;
            if (last_col) begin
              rd_col    <= '0;
              rd_shadow <= ~rd_shadow;
            end else begin
              rd_col <= rd_col + 1'b1;
            end
          end else begin
            rd_line <= rd_line + 1'b1;
          end
          state <= (can_issue && !block_end) ? RD_LO : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- RAM array ----------------
  lane_t ram_rdata [NUM_COL];

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    drain_ram_256 #(
      .AW(ADDR_W)
    ) u_ram (
      .clk  (clk),
      .we   (wr_en),
      .waddr(wr_addr),
      .wdata(res_data[c*LANE_W +: LANE_W]),
      .raddr(rd_addr),
      .rdata(ram_rdata[c])
    );
  end

  // ---------------- line assembly ----------------
  // All RAMs share one read address; the column register is delayed to line
  // up with the one-cycle read latency.
  logic [COL_W-1:0] col_q;
  logic             lo_pending;
  logic             hi_pending;
  lane_t            lo_hold;
  lane_t            rd_lane;
  logic             push;
  line_t            push_data;
  logic             pop;

  assign rd_lane   = ram_rdata[col_q];
  assign push      = hi_pending;
  assign push_data = {rd_lane, lo_hold};
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      lo_pending <= 1'b0;
      hi_pending <= 1'b0;
      lo_hold    <= '0;
    end else begin
      col_q      <= rd_col;
      lo_pending <= (state == RD_LO);
      hi_pending <= (state == RD_HI);
      if (lo_pending) begin
        lo_hold <= rd_lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({(state == RD_LO), push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  drain_line_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (out_data),
    .head_valid(out_valid),
    .count     (fifo_count)
  );

  // ---------------- block completion ----------------
  logic [OUT_W-1:0] out_line_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_line_cnt   <= '0;
      block_done     <= 1'b0;
      blocks_drained <= 16'd0;
    end else begin
      block_done <= 1'b0;
      if (pop) begin
        if (out_line_cnt == OUT_W'(LINES_PER_BLOCK - 1)) begin
          out_line_cnt   <= '0;
          block_done     <= 1'b1;
          blocks_drained <= blocks_drained + 16'd1;
        end else begin
          out_line_cnt <= out_line_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_drain_c.sv
// tb/tb_drain_c.sv - scoreboard bench for drain_c
module tb_drain_c;

  localparam int NC  = 2;
  localparam int RPB = 256;
  localparam int FD  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              res_valid;
  logic [NC*256-1:0] res_data;
  logic              res_ready;
  logic              out_valid;
  logic [511:0]      out_data;
  logic              out_ready = 1'b0;
  logic              block_done;
  logic              overflow_err;
  logic [15:0]       blocks_drained;

  int total = 0;
  int bad   = 0;

  logic [511:0] exp_q[$];
  logic [511:0] exp_line;
  int           lines_seen = 0;
  int           done_count = 0;
  int           ready_mode = 1;
  logic         held_valid = 1'b0;
  logic [511:0] held_data;
  logic         prev_done  = 1'b0;

  drain_c #(
    .NUM_COL(NC),
    .ROWS_PER_BLOCK(RPB),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_ready     (res_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .block_done    (block_done),
    .overflow_err  (overflow_err),
    .blocks_drained(blocks_drained)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] word(input int blk, input int c, input int r);
    logic [31:0] k;
    k = {blk[7:0], c[7:0], r[15:0]};
    return {192'd0, ~k, k};
  endfunction

  function automatic logic [NC*256-1:0] beat(input int blk, input int r);
    logic [NC*256-1:0] v;
    for (int c = 0; c < NC; c++) v[c*256 +: 256] = word(blk, c, r);
    return v;
  endfunction

  task automatic push_block_exp(input int blk);
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < RPB/2; k++)
        exp_q.push_back({word(blk, c, 2*k+1), word(blk, c, 2*k)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // out_ready driver: 0 = low, 1 = high, 2 = random ~30% high
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 99) < 30);
    endcase
  end

  // Output monitor: scoreboard pop, stall stability, block_done pulse shape
  always @(negedge clk) begin
    if (reset) begin
      held_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (held_valid && out_valid) begin
        total++;
        if (out_data !== held_data) begin
          bad++;
          $display("FAIL stall_stable got=%h want=%h", out_data, held_data);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_line got=%h want=none", out_data);
        end else begin
          exp_line = exp_q.pop_front();
          if (out_data !== exp_line) begin
            bad++;
            $display("FAIL line_data got=%h want=%h", out_data, exp_line);
          end
        end
        lines_seen++;
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      if (block_done) begin
        done_count++;
        total++;
        if (prev_done) begin
          bad++;
          $display("FAIL block_done_width got=2+ cycles want=1");
        end
      end
      prev_done = block_done;
    end
  end

  task automatic send_block(input int blk);
    int w;
    for (int r = 0; r < RPB; r++) begin
      w = 0;
      while (!res_ready && w < 5000) begin
        res_valid = 1'b0;
        tick();
        w++;
      end
      if (!res_ready) begin
        total++;
        bad++;
        $display("FAIL send_wait got=res_ready0 want=res_ready1 blk=%0d row=%0d", blk, r);
        res_valid = 1'b0;
        return;
      end
      res_valid = 1'b1;
      res_data  = beat(blk, r);
      tick();
    end
    res_valid = 1'b0;
    push_block_exp(blk);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got=%0d left want=0", name, exp_q.size());
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    res_valid  = 1'b0;
    res_data   = '0;
    ready_mode = 1;
    repeat (3) tick();
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL rst_res_ready got=%b want=1", res_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 512'd0) begin bad++; $display("FAIL rst_out_data got=%h want=0", out_data); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow_err); end
    total++; if (blocks_drained !== 16'd0) begin bad++; $display("FAIL rst_blocks got=%0d want=0", blocks_drained); end
    total++; if (block_done !== 1'b0) begin bad++; $display("FAIL rst_block_done got=%b want=0", block_done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_one_block();
    int lat;
    int d0;
    ready_mode = 1;
    d0 = done_count;
    for (int r = 0; r < RPB; r++) begin
      res_valid = 1'b1;
      res_data  = beat(1, r);
      tick();
    end
    res_valid = 1'b0;
    push_block_exp(1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    total++; if (lat != 4) begin bad++; $display("FAIL first_valid_latency got=%0d want=4", lat); end
    wait_drain("one_block", 2000);
    total++; if (done_count - d0 != 1) begin bad++; $display("FAIL one_block_done got=%0d want=1", done_count - d0); end
    total++; if (blocks_drained !== 16'd1) begin bad++; $display("FAIL one_block_count got=%0d want=1", blocks_drained); end
  endtask

  task automatic test_double_fill();
    ready_mode = 0;
    repeat (2) tick();
    for (int b = 2; b <= 3; b++) begin
      for (int r = 0; r < RPB; r++) begin
        res_valid = 1'b1;
        res_data  = beat(b, r);
        tick();
        if (b == 3 && r == RPB - 2) begin
          total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL ready_before_last got=%b want=1", res_ready); end
        end
      end
      push_block_exp(b);
    end
    res_valid = 1'b0;
    total++; if (res_ready !== 1'b0) begin bad++; $display("FAIL ready_fall got=%b want=0", res_ready); end
    res_valid = 1'b1;
    res_data  = beat(9, 0);
    tick();
    res_valid = 1'b0;
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL overflow_set got=%b want=1", overflow_err); end
    repeat (20) tick();
    total++; if (dut.fifo_count !== 3'd4) begin bad++; $display("FAIL fifo_full_count got=%0d want=4", dut.fifo_count); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fifo_full_valid got=%b want=1", out_valid); end
    total++; if (res_ready !== 1'b0) begin bad++; $display("FAIL ready_held_low got=%b want=0", res_ready); end
    ready_mode = 1;
    wait_drain("double", 4000);
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%b want=1", overflow_err); end
    total++; if (blocks_drained !== 16'd3) begin bad++; $display("FAIL double_count got=%0d want=3", blocks_drained); end
  endtask

  task automatic test_random_ready();
    int l0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
    l0 = lines_seen;
    ready_mode = 2;
    for (int b = 4; b <= 7; b++) send_block(b);
    wait_drain("random", 20000);
    ready_mode = 1;
    total++; if (lines_seen - l0 != 4*NC*RPB/2) begin bad++; $display("FAIL random_lines got=%0d want=%0d", lines_seen - l0, 4*NC*RPB/2); end
    total++; if (blocks_drained !== 16'd4) begin bad++; $display("FAIL random_count got=%0d want=4", blocks_drained); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL random_overflow got=%b want=0", overflow_err); end
  endtask

  task automatic test_coincide();
    int refused;
    ready_mode = 1;
    repeat (2) tick();
    for (int r = 0; r < RPB; r++) begin
      res_valid = 1'b1;
      res_data  = beat(10, r);
      tick();
    end
    res_valid = 1'b0;
    push_block_exp(10);
    // Reads of block 10 run for 2*RPB cycles; finish block 11 on the release cycle.
    repeat (RPB) tick();
    refused = 0;
    for (int r = 0; r < RPB; r++) begin
      if (res_ready !== 1'b1) refused++;
      res_valid = 1'b1;
      res_data  = beat(11, r);
      tick();
    end
    res_valid = 1'b0;
    push_block_exp(11);
    total++; if (refused != 0) begin bad++; $display("FAIL coincide_refused got=%0d want=0", refused); end
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL coincide_ready got=%b want=1", res_ready); end
    wait_drain("coincide", 3000);
    total++; if (blocks_drained !== 16'd6) begin bad++; $display("FAIL coincide_count got=%0d want=6", blocks_drained); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL coincide_overflow got=%b want=0", overflow_err); end
  endtask

  task automatic test_reset_mid();
    int l0;
    int n;
    ready_mode = 1;
    l0 = lines_seen;
    send_block(12);
    n = 0;
    while (lines_seen < l0 + 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++; if (lines_seen < l0 + 100) begin bad++; $display("FAIL mid_wait got=%0d want=100", lines_seen - l0); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
    total++; if (blocks_drained !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", blocks_drained); end
    total++; if (res_ready !== 1'b1) begin bad++; $display("FAIL mid_res_ready got=%b want=1", res_ready); end
    total++; if (out_data !== 512'd0) begin bad++; $display("FAIL mid_out_data got=%h want=0", out_data); end
    reset = 1'b0;
    exp_q.delete();
    tick();
    send_block(13);
    wait_drain("post_reset", 2000);
    total++; if (blocks_drained !== 16'd1) begin bad++; $display("FAIL post_reset_count got=%0d want=1", blocks_drained); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_one_block();
    test_double_fill();
    test_random_ready();
    test_coincide();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drain_c.md
Name: drain_c

Overview:
Output-side counterpart of the B/A input feeders. Collects per-column 256-bit C result lanes from the systolic array into double-buffered per-column RAMs. Drains them as 512-bit lines toward the write-back path over a valid/ready handshake. The array fills one bank while the other drains, with backpressure to the array when both banks are occupied.

Parameters:
NUM_COL, 2, number of PE columns (1..8); one 256-bit result lane per column
ROWS_PER_BLOCK, 256, 256-bit words per column per block; must be even, power of 2
FIFO_DEPTH, 4, output line FIFO entries (power of 2, >=4)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
res_valid  input  1  result beat valid; all column lanes carry data this cycle
res_data  input  NUM_COL*256  lane c = bits [(c+1)*256-1 : c*256]
res_ready  output  1  drain can accept a beat (bank_count<2)
out_valid  output  1  out_data valid
out_data  output  512  packed line: [255:0]=even row, [511:256]=odd row
out_ready  input  1  downstream accepts line
block_done  output  1  1-cycle pulse when the last line of a block is accepted
overflow_err  output  1  sticky: beat presented while res_ready=0
blocks_drained  output  16  count of completed blocks, wraps at 2^16

Behaviour:
- Reset values: res_ready=1, out_valid=0, out_data=0, block_done=0, overflow_err=0, blocks_drained=0, all counters/shadows=0, FIFO empty.
- Write side:
  - Beat accepted when res_valid && res_ready.
  - Every column RAM is written at addr {wr_shadow, wr_row}.
  - wr_row increments per accepted beat. At wr_row==ROWS_PER_BLOCK-1, wr_row wraps to 0, wr_shadow toggles, and bank_count increments.
- res_ready = (bank_count<2), registered-state derived with no comb path from out_ready.
- Beat with res_valid && !res_ready: discarded, no counter change, overflow_err set until reset.
- bank_count is 0..2. Same-cycle write-complete and read-release leave it unchanged.
- Read FSM states:
  - IDLE: go to RD_LO when bank_count>0 and fifo_count+inflight <= FIFO_DEPTH-1.
  - RD_LO: read even row at {rd_shadow, rd_line, 1'b0} of column rd_col.
  - RD_HI: read odd row at {rd_shadow, rd_line, 1'b1}. Next state is RD_LO if the issue condition still holds and more lines remain, otherwise IDLE.
- RAM read latency is 1 cycle. The lo half is captured in a holding register; the line is pushed to the FIFO in the cycle hi data returns.
- Read order: column 0 lines 0..ROWS_PER_BLOCK/2-1, then column 1, etc.
- Bank release: when the hi read of the last line of the last column issues, bank_count decrements, rd_shadow toggles, and rd_line/rd_col clear.
- inflight counts issued-but-not-pushed lines, so the FIFO never overflows.
- Peak throughput is 1 line / 2 cycles.
- Latency: last beat accepted in cycle T gives out_valid=1 first in cycle T+4, with an empty FIFO and an idle FSM.
- out_data/out_valid are driven directly from the FIFO head. They hold stable while out_valid && !out_ready.
- block_done pulses in the cycle after acceptance of the block's final line. blocks_drained increments in that same cycle.
- Reset mid-operation discards all buffered data. Post-reset writes start at bank 0, row 0.

Decomposition:
- Shared package sgemm_pkg: LANE_W=256, LINE_W=512, typedef lane_t, line_t, enum drain_state_t {IDLE, RD_LO, RD_HI}.
- Sub-module drain_line_fifo: synchronous FIFO_DEPTH x 512, with count output, push/pop, and pop-when-empty ignored.
- RAM: per-column simple dual-port 256-bit, depth 2*ROWS_PER_BLOCK, registered read, named drain_ram_256.

Test Plan:
- Reset with res_valid=0 -> res_ready=1, out_valid=0, overflow_err=0, blocks_drained=0.
- One block, NUM_COL=2, ROWS_PER_BLOCK=256, lane word = {col, row} pattern, out_ready=1 -> expected responses:
  - 256 lines in order; line k of col c = {row 2k+1, row 2k}.
  - First out_valid at T+4.
  - block_done single pulse; blocks_drained=1.
- Double-buffer fill with out_ready=0 and 512 beats -> expected responses:
  - res_ready falls the cycle after beat 512.
  - Beat 513 with res_valid=1 sets overflow_err=1 and is discarded.
  - FIFO holds exactly 4 lines.
- Random out_ready (30% high) over 4 back-to-back blocks -> expected responses:
  - 1024 lines, no loss or reorder.
  - out_data stable while stalled; blocks_drained=4.
- Write-completion cycle coincides with bank release -> bank_count unchanged, res_ready stays 1, no lost beat.
- Reset asserted after 100 lines drained -> expected responses:
  - Next cycle out_valid=0 and counters=0.
  - Following block drains from bank 0 row 0 with correct data.
